mem_wb_skid: RTL and testbench

Parametrised MEM/WB pipeline register with a valid/ready handshake and a one-entry skid buffer. It sits between the memory stage and the register file / CSR file. Unlike the fixed stage register it replaces, it adds:
- backpressure from write-back;
- x0 write suppression;
- a qualified retire pulse;
- a free-running retired-instruction counter.

---
 rtl/mem_wb_skid_pkg.sv | 25 ++
 rtl/mem_wb_skid_skid_buf.sv | 73 +++++++
 rtl/mem_wb_skid.sv | 87 ++++++++
 tb/tb_mem_wb_skid.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_skid_pkg.sv
// Shared MEM/WB definitions: default widths, write-back payload, constants.
package mem_wb_skid_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_RADDR_W    = 5;
  localparam int DEF_CSR_ADDR_W = 12;
  localparam int DEF_CNT_W      = 64;

  // Constants formerly kept in the global defines.
  localparam logic [DEF_RADDR_W-1:0] ZERO_REG      = '0;
  localparam logic                   WRITE_DISABLE = 1'b0;
  localparam logic [DEF_XLEN-1:0]    ZERO          = '0;

  // Write-back payload at the default widths; field order matches the
  // flattened vector carried through the skid buffer.
  typedef struct packed {
    logic                      reg_we;
    logic [DEF_RADDR_W-1:0]    reg_waddr;
    logic [DEF_XLEN-1:0]       reg_wdata;
    logic                      csr_we;
    logic [DEF_CSR_ADDR_W-1:0] csr_waddr;
    logic [DEF_XLEN-1:0]       csr_wdata;
  } wb_payload_t;

endpackage

// File: rtl/mem_wb_skid_skid_buf.sv
// Generic two-entry valid/ready buffer: head (main) plus one skid entry.
// ready_o comes straight from the skid valid flop, so upstream never sees
// a combinational path from ready_i.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, ret;

  assign ready_o = ~skid_vld_q;
  assign valid_o = main_vld_q;
  assign data_o  = main_q;
  assign acc     = valid_i & ready_o;
  assign ret     = main_vld_q & ready_i;

  // Next-state: flush wins; otherwise refill head from skid, then from input.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      main_d     = '0;
      skid_d     = '0;
    end else if (!main_vld_q || ret) begin
      if (skid_vld_q) begin
        // ready_o is low here, so acc is 0 and skid simply empties.
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = acc;
        if (acc) skid_d = data_i;
      end else begin
        main_vld_d = acc;
        if (acc) main_d = data_i;
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_d     = data_i;
    end
  end

  // Entry registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB stage register with backpressure, x0 write suppression,
// qualified retire pulse and a free-running retired-instruction counter.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int RADDR_W    = DEF_RADDR_W,
  parameter int CSR_ADDR_W = DEF_CSR_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  reg_we_i,
  input  logic [RADDR_W-1:0]    reg_waddr_i,
  input  logic [XLEN-1:0]       reg_wdata_i,
  input  logic                  csr_we_i,
  input  logic [CSR_ADDR_W-1:0] csr_waddr_i,
  input  logic [XLEN-1:0]       csr_wdata_i,
  input  logic                  flush_int_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  reg_we_o,
  output logic [RADDR_W-1:0]    reg_waddr_o,
  output logic [XLEN-1:0]       reg_wdata_o,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  output logic                  instret_incr_o,
  output logic [CNT_W-1:0]      retire_cnt_o
);

  localparam int PW = 2 + RADDR_W + CSR_ADDR_W + 2 * XLEN;

  logic [PW-1:0]    pl_in, pl_head;
  logic             hd_reg_we, hd_csr_we;
  logic             retire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign pl_in = {reg_we_i, reg_waddr_i, reg_wdata_i,
                  csr_we_i, csr_waddr_i, csr_wdata_i};

  skid_buf #(.W(PW)) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_int_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (pl_in),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (pl_head)
  );

  assign {hd_reg_we, reg_waddr_o, reg_wdata_o,
          hd_csr_we, csr_waddr_o, csr_wdata_o} = pl_head;

  // A retire still counts in a flush cycle: the head has been consumed.
  assign retire         = valid_o & ready_i;
  assign instret_incr_o = retire;

  // Strobes only fire on the consuming cycle; writes to x0 are dropped.
  always_comb begin
    reg_we_o = WRITE_DISABLE;
    csr_we_o = WRITE_DISABLE;
    if (retire) begin
      reg_we_o = hd_reg_we & (reg_waddr_o != RADDR_W'(ZERO_REG));
      csr_we_o = hd_csr_we;
    end
  end

  // Retired-instruction count, wrapping at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= CNT_W'(ZERO);
    else         cnt_q <= cnt_d;
  end

  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed + scoreboarded streaming bench for mem_wb_skid.
module tb_mem_wb_skid;
  import mem_wb_skid_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_reg_we, in_csr_we, flush, rdy;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata, in_cdata;
  logic [11:0] in_caddr;

  logic        ready_o, valid_o, reg_we_o, csr_we_o, instret;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o, csr_wdata_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] cnt;

  logic        ready4, valid4, reg_we4, csr_we4, instret4;
  logic [4:0]  reg_waddr4;
  logic [31:0] reg_wdata4, csr_wdata4;
  logic [11:0] csr_waddr4;
  logic [3:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_skid dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(in_valid), .ready_o(ready_o),
    .reg_we_i(in_reg_we), .reg_waddr_i(in_waddr), .reg_wdata_i(in_wdata),
    .csr_we_i(in_csr_we), .csr_waddr_i(in_caddr), .csr_wdata_i(in_cdata),
    .flush_int_i(flush), .valid_o(valid_o), .ready_i(rdy),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .instret_incr_o(instret), .retire_cnt_o(cnt)
  );

  // Narrow-counter instance sharing all inputs, used for the wrap check.
  mem_wb_skid #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(in_valid), .ready_o(ready4),
    .reg_we_i(in_reg_we), .reg_waddr_i(in_waddr), .reg_wdata_i(in_wdata),
    .csr_we_i(in_csr_we), .csr_waddr_i(in_caddr), .csr_wdata_i(in_cdata),
    .flush_int_i(flush), .valid_o(valid4), .ready_i(rdy),
    .reg_we_o(reg_we4), .reg_waddr_o(reg_waddr4), .reg_wdata_o(reg_wdata4),
    .csr_we_o(csr_we4), .csr_waddr_o(csr_waddr4), .csr_wdata_o(csr_wdata4),
    .instret_incr_o(instret4), .retire_cnt_o(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input logic v, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic cwe,
                     input logic [11:0] ca, input logic [31:0] cd);
    in_valid = v; in_reg_we = we; in_waddr = wa; in_wdata = wd;
    in_csr_we = cwe; in_caddr = ca; in_cdata = cd;
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0);
  endtask

  wb_payload_t q[$];
  wb_payload_t cur, ex;
  int          pushes = 0;

  // Streaming monitor: push accepted inputs, compare retired heads in order.
  task automatic mon();
    if (in_valid && ready_o) begin
      q.push_back(cur);
      pushes++;
    end
    if (valid_o && rdy) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        ex = q.pop_front();
        chk("sb_ctl", {reg_we_o, reg_waddr_o, csr_we_o, csr_waddr_o, instret},
            {ex.reg_we && (ex.reg_waddr != 5'd0), ex.reg_waddr, ex.csr_we, ex.csr_waddr, 1'b1});
        chk("sb_data", {reg_wdata_o, csr_wdata_o}, {ex.reg_wdata, ex.csr_wdata});
      end
    end else begin
      chk("sb_nostrobe", {reg_we_o, csr_we_o, instret}, 3'b000);
    end
  endtask

  int          pulses;
  logic [63:0] base;

  initial begin
    // Reset with random inputs.
    rst_n = 1'b0;
    put(1'b1, 1'b1, 5'd3, 32'h5555, 1'b1, 12'h1, 32'h1);
    flush = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      put(1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
          12'($urandom), $urandom);
      flush = 1'($urandom); rdy = 1'($urandom);
    end
    smp();
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_strobes", {reg_we_o, csr_we_o, instret}, 0);
    chk("rst_payload", {reg_waddr_o, reg_wdata_o, csr_waddr_o, csr_wdata_o}, 0);
    chk("rst_cnt", cnt, 0);

    tick(); rst_n = 1'b1; idle(); flush = 1'b0; rdy = 1'b1;
    smp();
    // First instruction: one-cycle latency to the head.
    tick(); put(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'd0, 32'd0);
    smp(); chk("first_ready", ready_o, 1); chk("first_not_yet", valid_o, 0);
    tick(); idle();
    smp();
    chk("first_ctl", {valid_o, reg_we_o, reg_waddr_o, instret}, {1'b1, 1'b1, 5'd5, 1'b1});
    chk("first_data", reg_wdata_o, 32'hDEADBEEF);
    tick(); smp();
    chk("first_cnt", cnt, 1); chk("first_empty", valid_o, 0);

    // Backpressure: A, B accepted, C held upstream.
    tick(); rdy = 1'b0; put(1'b1, 1'b1, 5'd1, 32'hA, 1'b0, 12'd0, 32'd0);
    smp(); chk("bp_acc_a", ready_o, 1);
    tick(); put(1'b1, 1'b1, 5'd2, 32'hB, 1'b0, 12'd0, 32'd0);
    smp(); chk("bp_acc_b", ready_o, 1);
    tick(); put(1'b1, 1'b1, 5'd3, 32'hC, 1'b0, 12'd0, 32'd0);
    smp(); chk("bp_full", {ready_o, valid_o, reg_we_o, instret}, 4'b0100);
    tick(); rdy = 1'b1;
    smp(); chk("bp_ret_a", {reg_we_o, reg_waddr_o, reg_wdata_o, instret, ready_o},
               {1'b1, 5'd1, 32'hA, 1'b1, 1'b0});
    tick();
    smp(); chk("bp_ret_b", {reg_we_o, reg_waddr_o, reg_wdata_o, instret, ready_o},
               {1'b1, 5'd2, 32'hB, 1'b1, 1'b1});
    tick(); idle();
    smp(); chk("bp_ret_c", {reg_we_o, reg_waddr_o, reg_wdata_o, instret},
               {1'b1, 5'd3, 32'hC, 1'b1});
    tick(); smp(); chk("bp_cnt", cnt, 4); chk("bp_empty", valid_o, 0);

    // x0 suppression, then a CSR-only write.
    tick(); put(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 12'd0, 32'd0);
    smp();
    tick(); put(1'b1, 1'b0, 5'd7, 32'h0, 1'b1, 12'h300, 32'hCAFE);
    smp(); chk("x0_ctl", {valid_o, reg_we_o, instret}, 3'b101);
    chk("x0_data", reg_wdata_o, 32'h1234);
    tick(); idle();
    smp(); chk("csr_ctl", {csr_we_o, csr_waddr_o, reg_we_o, instret}, {1'b1, 12'h300, 1'b0, 1'b1});
    chk("csr_data", csr_wdata_o, 32'hCAFE);
    tick(); smp(); chk("csr_cnt", cnt, 6);

    // Flush with both entries full and a new input presented.
    tick(); rdy = 1'b0; put(1'b1, 1'b1, 5'd9, 32'hD, 1'b1, 12'h9, 32'hD);
    smp();
    tick(); put(1'b1, 1'b1, 5'd10, 32'hE, 1'b1, 12'hA, 32'hE);
    smp();
    tick(); flush = 1'b1; put(1'b1, 1'b1, 5'd11, 32'hF, 1'b1, 12'hB, 32'hF);
    smp(); chk("fl_pre", {ready_o, valid_o, reg_we_o, csr_we_o}, 4'b0100);
    tick(); flush = 1'b0; idle(); rdy = 1'b1;
    smp(); chk("fl_post", {valid_o, ready_o, reg_we_o, csr_we_o, instret}, 5'b01000);
    chk("fl_zeroed", {reg_waddr_o, reg_wdata_o, csr_waddr_o, csr_wdata_o}, 0);
    tick(); smp(); chk("fl_cnt", cnt, 6); chk("fl_quiet", {valid_o, reg_we_o, csr_we_o}, 0);

    // Counter wrap: 17 retires into a 4-bit counter.
    tick(); rst_n = 1'b0; smp();
    chk("wrap_rst", cnt4, 0);
    tick(); rst_n = 1'b1; smp();
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      tick(); put(1'b1, 1'b1, 5'(i + 1), 32'(i), 1'b0, 12'd0, 32'd0);
      smp(); pulses += int'(instret);
    end
    tick(); idle(); smp(); pulses += int'(instret);
    tick(); smp();
    chk("wrap_pulses", 64'(pulses), 17);
    chk("wrap_cnt64", cnt, 17);
    chk("wrap_cnt4", cnt4, 1);

    // Random streaming with scoreboard.
    base = cnt;
    for (int c = 0; c < 10000; c++) begin
      tick();
      put(1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
          12'($urandom), $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cur = '{in_reg_we, in_waddr, in_wdata, in_csr_we, in_caddr, in_cdata};
      smp(); mon();
    end
    for (int c = 0; c < 4; c++) begin
      tick(); idle(); rdy = 1'b1;
      cur = '0;
      smp(); mon();
    end
    chk("sb_drained", 64'(q.size()), 0);
    chk("sb_cnt", cnt - base, 64'(pushes));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
